// File: rtl/exp_mask_gearbox.sv
// -----------------------------------------------------------------------------
// exp_mask_gearbox
//
// Repacks the SHAKE256 squeeze stream (IN_W-bit words) into output beats of
// EXP_NUM_SAMPLERS raw samples of EXP_SAMPLE_W bits each, feeding the
// ExpandMask stage (exp_mask_ctrl). One polynomial of NUM_COEFFS coefficients
// is produced per start_i, after which done_o pulses for one cycle.
//
// Bits are consumed LSB-first: bit 0 of the first input word becomes bit 0 of
// data_o[0].
//
// Ports
//   clk           clock
//   rst           synchronous reset, active-high
//   zeroize       synchronous clear, same effect as rst (drops buffered bits)
//   start_i       begin one polynomial (only honoured in IDLE)
//   data_valid_i  input word valid
//   data_hold_o   input stall; a word moves when data_valid_i & ~data_hold_o
//   data_i        input word, bit 0 is the first squeezed bit
//   data_valid_o  output beat valid
//   data_hold_i   downstream stall; a beat moves when data_valid_o & ~data_hold_i
//   data_o        output samples, data_o[0] holds the oldest bits
//   done_o        one-cycle pulse when the polynomial is complete
//
// Optional build macro EXP_MASK_GEARBOX_STALL_CNT_EN
//   Adds stall_cnt_o[15:0]: saturating count of RUN cycles without a valid
//   output beat. Cleared by rst, zeroize and by start_i in IDLE.
// -----------------------------------------------------------------------------
module exp_mask_gearbox #(
    parameter int IN_W             = 64,
    parameter int EXP_NUM_SAMPLERS = 4,
    parameter int EXP_SAMPLE_W     = 20,
    parameter int NUM_COEFFS       = 256
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         zeroize,
    input  logic                                         start_i,
    input  logic                                         data_valid_i,
    output logic                                         data_hold_o,
    input  logic [IN_W-1:0]                              data_i,
    output logic                                         data_valid_o,
    input  logic                                         data_hold_i,
    output logic [EXP_NUM_SAMPLERS-1:0][EXP_SAMPLE_W-1:0] data_o,
    output logic                                         done_o
`ifdef EXP_MASK_GEARBOX_STALL_CNT_EN
    ,
    output logic [15:0]                                  stall_cnt_o
`endif
);

    localparam int OUT_W     = EXP_NUM_SAMPLERS * EXP_SAMPLE_W;
    localparam int BUF_W     = IN_W + OUT_W;
    localparam int IN_WORDS  = NUM_COEFFS * EXP_SAMPLE_W / IN_W;
    localparam int OUT_BEATS = NUM_COEFFS / EXP_NUM_SAMPLERS;
    localparam int FILL_W    = $clog2(BUF_W + 1);
    localparam int ICNT_W    = $clog2(IN_WORDS + 1);
    localparam int OCNT_W    = $clog2(OUT_BEATS + 1);

    localparam logic [FILL_W-1:0] OUT_FILL = FILL_W'(OUT_W);
    localparam logic [FILL_W-1:0] IN_FILL  = FILL_W'(IN_W);
    localparam logic [ICNT_W-1:0] IN_LAST  = ICNT_W'(IN_WORDS);
    localparam logic [OCNT_W-1:0] OUT_LAST = OCNT_W'(OUT_BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_nxt;
    logic [BUF_W-1:0]    bits_q;
    logic [BUF_W-1:0]    bits_nxt;
    logic [FILL_W-1:0]   fill_q;
    logic [FILL_W-1:0]   fill_nxt;
    logic [FILL_W-1:0]   ins_pos;
    logic [ICNT_W-1:0]   in_cnt_q;
    logic [OCNT_W-1:0]   out_cnt_q;
    logic                word_xfer;
    logic                beat_xfer;

    assign word_xfer = data_valid_i & ~data_hold_o;
    assign beat_xfer = data_valid_o & ~data_hold_i;

    // Output samples come straight from the bit-queue register.
    assign data_o = bits_q[OUT_W-1:0];

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and handshake outputs
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt    = state_q;
        data_hold_o  = 1'b1;
        data_valid_o = 1'b0;
        done_o       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                data_valid_o = (fill_q >= OUT_FILL);
                // Accept a word only while it is guaranteed to fit after
                // the worst case of no beat leaving, and stop once every
                // word of the polynomial has been taken.
                data_hold_o  = (fill_q > OUT_FILL) || (in_cnt_q == IN_LAST);
                if (data_valid_o && !data_hold_i && (out_cnt_q == OUT_LAST)) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done_o    = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Bit-queue update: drop a beat from the bottom, then append the new word
    // directly above the surviving bits. Bits above fill are always zero, so
    // the append is a plain OR.
    // -------------------------------------------------------------------------
    always_comb begin
        bits_nxt = bits_q;
        fill_nxt = fill_q;
        ins_pos  = fill_q;
        if (beat_xfer) begin
            bits_nxt = bits_q >> OUT_W;
            fill_nxt = fill_q - OUT_FILL;
            ins_pos  = fill_q - OUT_FILL;
        end
        if (word_xfer) begin
            bits_nxt = bits_nxt | (BUF_W'(data_i) << ins_pos);
            fill_nxt = fill_nxt + IN_FILL;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers. Everything is held clear outside RUN, which also
    // discards any residue when the polynomial ends or is aborted.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || zeroize || (state_q != RUN)) begin
            bits_q    <= '0;
            fill_q    <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            bits_q <= bits_nxt;
            fill_q <= fill_nxt;
            if (word_xfer) begin
                in_cnt_q <= in_cnt_q + ICNT_W'(1);
            end
            if (beat_xfer) begin
                out_cnt_q <= out_cnt_q + OCNT_W'(1);
            end
        end
    end

`ifdef EXP_MASK_GEARBOX_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (rst || zeroize) begin
            stall_cnt_q <= '0;
        end else if ((state_q == IDLE) && start_i) begin
            stall_cnt_q <= '0;
        end else if ((state_q == RUN) && !data_valid_o && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_exp_mask_gearbox.sv
`timescale 1ns/1ps
module tb_exp_mask_gearbox;

    logic            clk = 1'b0;
    logic            rst;
    logic            zeroize;
    logic            start_i;
    logic            data_valid_i;
    logic            data_hold_o;
    logic [63:0]     data_i;
    logic            data_valid_o;
    logic            data_hold_i;
    logic [3:0][19:0] data_o;
    logic            done_o;
`ifdef EXP_MASK_GEARBOX_STALL_CNT_EN
    logic [15:0]     stall_cnt_o;
`endif

    always #5 clk = ~clk;

    exp_mask_gearbox dut (
        .clk          (clk),
        .rst          (rst),
        .zeroize      (zeroize),
        .start_i      (start_i),
        .data_valid_i (data_valid_i),
        .data_hold_o  (data_hold_o),
        .data_i       (data_i),
        .data_valid_o (data_valid_o),
        .data_hold_i  (data_hold_i),
        .data_o       (data_o),
        .done_o       (done_o)
`ifdef EXP_MASK_GEARBOX_STALL_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    localparam logic [79:0] FIRST_BEAT = {20'h32100, 20'h12345, 20'h6789A, 20'hBCDEF};
    localparam logic [63:0] PAT_W0 = 64'h0123456789ABCDEF;
    localparam logic [63:0] PAT_W1 = 64'hFEDCBA9876543210;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          beats_poly = 0;
    int          beats_total = 0;
    int          done_cnt = 0;
    int          last_beat_cyc = -10;
    bit          use_model = 1'b1;
    logic [79:0] expq[$];
    bit          mq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Monitor: pops the scoreboard on every beat transfer, checks hold
    // stability and done timing.
    initial begin : monitor
        bit          held_prev;
        logic [79:0] data_prev;
        held_prev = 1'b0;
        data_prev = '0;
        forever begin
            @(negedge clk);
            if (held_prev) begin
                check("hold_valid_stable", 80'(data_valid_o), 80'd1);
                check("hold_data_stable", data_o, data_prev);
            end
            held_prev = data_valid_o && data_hold_i;
            data_prev = data_o;
            if (data_valid_o && !data_hold_i) begin
                if (expq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", data_o);
                end else begin
                    check("beat", data_o, expq.pop_front());
                end
                beats_poly++;
                beats_total++;
                last_beat_cyc = cyc;
            end
            if (done_o) begin
                check("done_beats", 80'(beats_poly), 80'd64);
                check("done_latency", 80'(cyc - last_beat_cyc), 80'd1);
                done_cnt++;
                beats_poly = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference bit-slicing model: append 64 bits LSB-first, cut 80-bit beats.
    task automatic model_word(input logic [63:0] w);
        logic [79:0] b;
        if (!use_model) return;
        for (int i = 0; i < 64; i++) mq.push_back(w[i]);
        while (mq.size() >= 80) begin
            for (int j = 0; j < 80; j++) b[j] = mq.pop_front();
            expq.push_back(b);
        end
    endtask

    task automatic send_word(input logic [63:0] w);
        bit acc;
        acc = 1'b0;
        data_i = w;
        data_valid_i = 1'b1;
        for (int t = 0; t < 300 && !acc; t++) begin
            @(negedge clk);
            acc = !data_hold_o;
            @(posedge clk);
            #1;
        end
        if (!acc) fail_now("word_accept");
        else model_word(w);
    endtask

    task automatic send_random(input int n);
        for (int k = 0; k < n; k++) send_word({$urandom, $urandom});
        data_valid_i = 1'b0;
    endtask

    task automatic do_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic do_zeroize();
        zeroize = 1'b1;
        tick();
        zeroize = 1'b0;
        expq.delete();
        mq.delete();
        beats_poly = 0;
    endtask

    task automatic wait_done(input int prev);
        int t;
        t = 0;
        while (done_cnt == prev && t < 3000) begin
            tick();
            t++;
        end
        if (done_cnt == prev) fail_now("done_wait");
    endtask

    task automatic wait_beats(input int target);
        int t;
        t = 0;
        while (beats_total < target && t < 3000) begin
            tick();
            t++;
        end
        if (beats_total < target) fail_now("beat_wait");
    endtask

    task automatic hold_window();
        wait_beats(beats_total + 20);
        data_hold_i = 1'b1;
        repeat (9) tick();
        @(negedge clk);
        check("t4_hold_o_full", 80'(data_hold_o), 80'd1);
        check("t4_valid_held", 80'(data_valid_o), 80'd1);
        tick();
        data_hold_i = 1'b0;
    endtask

    task automatic check_idle(input string name);
        @(negedge clk);
        check({name, "_valid"}, 80'(data_valid_o), 80'd0);
        check({name, "_hold"}, 80'(data_hold_o), 80'd1);
        check({name, "_done"}, 80'(done_o), 80'd0);
    endtask

    task automatic pattern_first_beat(input string name);
        int base;
        base = beats_total;
        use_model = 1'b0;
        do_start();
        expq.push_back(FIRST_BEAT);
        send_word(PAT_W0);
        send_word(PAT_W1);
        data_valid_i = 1'b0;
        wait_beats(base + 1);
        check({name, "_queue_empty"}, 80'(expq.size()), 80'd0);
        use_model = 1'b1;
        do_zeroize();
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : stim
        int prev;
        int base;
        rst = 1'b1;
        zeroize = 1'b0;
        start_i = 1'b0;
        data_valid_i = 1'b0;
        data_hold_i = 1'b0;
        data_i = '0;
        tick();
        rst = 1'b0;

        // 1: reset state
        @(negedge clk);
        check("t1_valid", 80'(data_valid_o), 80'd0);
        check("t1_hold", 80'(data_hold_o), 80'd1);
        check("t1_done", 80'(done_o), 80'd0);
        check("t1_data", data_o, 80'd0);
        tick();

        // 2: hand-computed first beat
        pattern_first_beat("t2");

        // 3: full polynomial, back-to-back words
        prev = done_cnt;
        do_start();
        send_random(80);
        @(negedge clk);
        check("t3_hold_after_last", 80'(data_hold_o), 80'd1);
        wait_done(prev);
        check_idle("t3_idle");
        check("t3_queue_empty", 80'(expq.size()), 80'd0);
        check("t3_model_empty", 80'(mq.size()), 80'd0);

        // 4: downstream stall mid-stream
        prev = done_cnt;
        do_start();
        fork
            send_random(80);
            hold_window();
        join
        wait_done(prev);
        check("t4_queue_empty", 80'(expq.size()), 80'd0);

        // 5: zeroize after 30 beats, then restart
        base = beats_total;
        do_start();
        send_random(38);
        wait_beats(base + 30);
        check("t5_queue_empty", 80'(expq.size()), 80'd0);
        do_zeroize();
        check_idle("t5_after_zeroize");
        pattern_first_beat("t5");

`ifdef EXP_MASK_GEARBOX_STALL_CNT_EN
        // 6: stall counter with a 3-cycle input gap after the first beat
        prev = done_cnt;
        do_start();
        send_word(PAT_W0);
        send_word(PAT_W1);
        data_valid_i = 1'b0;
        @(negedge clk);
        check("t6_stall_first_beat", 80'(stall_cnt_o), 80'd2);
        check("t6_first_valid", 80'(data_valid_o), 80'd1);
        tick();
        tick();
        tick();
        check("t6_stall_after_gap", 80'(stall_cnt_o), 80'd4);
        send_random(78);
        wait_done(prev);
        check("t6_stall_kept", 80'(stall_cnt_o >= 16'd4), 80'd1);
        do_start();
        check("t6_stall_cleared", 80'(stall_cnt_o), 80'd0);
        do_zeroize();
`endif

        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
